// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and helpers for the serial datapath
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } collector_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ser_shift_in.sv
// rtl/ser_shift_in.sv - receive-side shift register, bit enters at MSB (LSB_FIRST) or LSB
module ser_shift_in #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Shift_En,
  input  logic             Bit_In,
  output logic [WIDTH-1:0] Shifted
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {Bit_In, r_sr[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], Bit_In};
    end
  endgenerate

  // Post-shift value, so the top can capture a completed word on the same edge
  assign Shifted = w_shifted;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sr <= '0;
    end else if (Clear) begin
      r_sr <= '0;
    end else if (Shift_En) begin
      r_sr <= w_shifted;
    end
  end

endmodule

// File: rtl/serial_byte_collector.sv
// rtl/serial_byte_collector.sv - serial-to-parallel collector with one-entry holding register
module serial_byte_collector
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Bit_In,
  input  logic                     Bit_Valid,
  input  logic                     Clear,
  input  logic                     Data_Ready,
  output logic [WIDTH-1:0]         Data_Out,
  output logic                     Data_Valid,
  output logic                     Overrun,
  output logic [$clog2(WIDTH)-1:0] Bit_Count,
  output logic                     Busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  collector_state_t r_state, w_state_nxt;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  logic             w_busy;

  assign w_accept  = Bit_Valid && !Clear;
  assign w_last    = w_accept && (r_count == LAST_CNT);
  assign w_consume = r_valid && Data_Ready;

  ser_shift_in #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (Clear),
    .Shift_En(w_accept),
    .Bit_In  (Bit_In),
    .Shifted (w_word)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (Clear || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_SHIFT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (Clear) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  // A word completing into an occupied, unconsumed holding register is lost
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_last && (!r_valid || w_consume)) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (Clear) begin
        r_overrun <= 1'b0;
      end else if (w_last && r_valid && !w_consume) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign Data_Out   = r_data;
  assign Data_Valid = r_valid;
  assign Overrun    = r_overrun;
  assign Bit_Count  = r_count;
  assign Busy       = w_busy;

endmodule

// File: tb/tb_serial_byte_collector.sv
// tb/tb_serial_byte_collector.sv - randomized bench with word-level reference model
module tb_serial_byte_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bin = 1'b0;
  logic         bv  = 1'b0;
  logic         clr = 1'b0;
  logic         rdy = 1'b0;

  logic [W-1:0] l_data, m_data_o;
  logic         l_valid, m_valid_o, l_ovr, m_ovr_o, l_busy, m_busy_o;
  logic [2:0]   l_cnt, m_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int           m_bits[W];
  int           m_cnt;
  logic         m_valid;
  logic         m_ovr;
  logic [W-1:0] m_word_l;
  logic [W-1:0] m_word_m;

  always #5 clk = ~clk;

  serial_byte_collector #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .Clk(clk), .Reset(rst), .Bit_In(bin), .Bit_Valid(bv), .Clear(clr),
    .Data_Ready(rdy), .Data_Out(l_data), .Data_Valid(l_valid),
    .Overrun(l_ovr), .Bit_Count(l_cnt), .Busy(l_busy)
  );

  serial_byte_collector #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .Clk(clk), .Reset(rst), .Bit_In(bin), .Bit_Valid(bv), .Clear(clr),
    .Data_Ready(rdy), .Data_Out(m_data_o), .Data_Valid(m_valid_o),
    .Overrun(m_ovr_o), .Bit_Count(m_cnt_o), .Busy(m_busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_word_l = '0;
    m_word_m = '0;
    for (int k = 0; k < W; k++) m_bits[k] = 0;
  endtask

  // Word assembled from arrival order: LSB-first puts arrival k at bit k,
  // MSB-first puts it at bit W-1-k.
  task automatic model_step(input logic i_bv, input logic i_bin, input logic i_clr, input logic i_rdy);
    logic consume;
    logic done;
    logic [W-1:0] wl, wm;
    consume = m_valid && i_rdy;
    done = 1'b0;
    wl = '0;
    wm = '0;
    if (i_clr) begin
      m_cnt = 0;
      m_ovr = 1'b0;
    end else if (i_bv) begin
      m_bits[m_cnt] = int'(i_bin);
      m_cnt++;
      if (m_cnt == W) begin
        done = 1'b1;
        m_cnt = 0;
        for (int k = 0; k < W; k++) begin
          wl[k]       = m_bits[k][0];
          wm[W-1-k]   = m_bits[k][0];
        end
      end
    end
    if (done && (!m_valid || consume)) begin
      m_word_l = wl;
      m_word_m = wm;
      m_valid  = 1'b1;
    end else if (done) begin
      m_ovr = 1'b1;
    end else if (consume) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  {31'd0, l_valid}, {31'd0, m_valid});
    check({tag, ".ovr"},    {31'd0, l_ovr},   {31'd0, m_ovr});
    check({tag, ".cnt"},    {29'd0, l_cnt},   m_cnt);
    check({tag, ".busy"},   {31'd0, l_busy},  {31'd0, (m_cnt != 0)});
    check({tag, ".data_l"}, {24'd0, l_data},  {24'd0, m_word_l});
    check({tag, ".data_m"}, {24'd0, m_data_o}, {24'd0, m_word_m});
    check({tag, ".valid_m"}, {31'd0, m_valid_o}, {31'd0, m_valid});
    check({tag, ".ovr_m"},  {31'd0, m_ovr_o}, {31'd0, m_ovr});
    check({tag, ".cnt_m"},  {29'd0, m_cnt_o}, m_cnt);
    check({tag, ".busy_m"}, {31'd0, m_busy_o}, {31'd0, (m_cnt != 0)});
  endtask

  task automatic cycle(input logic i_bv, input logic i_bin, input logic i_clr, input logic i_rdy,
                       input string tag);
    bv  = i_bv;
    bin = i_bin;
    clr = i_clr;
    rdy = i_rdy;
    @(posedge clk);
    model_step(i_bv, i_bin, i_clr, i_rdy);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic i_rdy, input string tag);
    for (int i = 0; i < W; i++) cycle(1'b1, v[i], 1'b0, i_rdy, tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // A5 held until consumed; MSB-first instance sees the same bits as 0xA5
    send_word(8'hA5, 1'b0, "a5");
    check("a5.lsb_const", {24'd0, l_data}, 32'hA5);
    check("a5.msb_const", {24'd0, m_data_o}, 32'hA5);
    check("a5.valid_const", {31'd0, l_valid}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "a5_hold");
    check("a5.hold_const", {24'd0, l_data}, 32'hA5);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "a5_take");
    check("a5.take_const", {31'd0, l_valid}, 32'd0);

    // bits 1,1,0,0,0,0,0,0
    send_word(8'h03, 1'b0, "c0");
    check("c0.msb_const", {24'd0, m_data_o}, 32'hC0);
    check("c0.lsb_const", {24'd0, l_data}, 32'h03);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "c0_take");

    // back-to-back with ready held high
    send_word(8'h3C, 1'b1, "b2b0");
    check("b2b.first_const", {24'd0, l_data}, 32'h3C);
    send_word(8'hFF, 1'b1, "b2b1");
    check("b2b.second_const", {24'd0, l_data}, 32'hFF);
    check("b2b.ovr_const", {31'd0, l_ovr}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "b2b_take");

    // overrun then clear
    send_word(8'hA5, 1'b0, "ov0");
    send_word(8'h11, 1'b0, "ov1");
    check("ov.data_const", {24'd0, l_data}, 32'hA5);
    check("ov.flag_const", {31'd0, l_ovr}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "ov_clr");
    check("ov.cleared_const", {31'd0, l_ovr}, 32'd0);
    check("ov.still_valid_const", {31'd0, l_valid}, 32'd1);

    // clear with a simultaneous bit after 3 bits, consuming the held word too
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "abort");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "abort_clr");
    check("abort.cnt_const", {29'd0, l_cnt}, 32'd0);
    check("abort.busy_const", {31'd0, l_busy}, 32'd0);
    send_word(8'h5A, 1'b0, "clean");
    check("clean.data_const", {24'd0, l_data}, 32'h5A);

    // async reset between edges
    for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 1'b0, 1'b0, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 39) == 0),
            1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_byte_collector.md
# serial_byte_collector

Serial-to-parallel receive end for the shift-register datapath: takes one bit per qualified clock and assembles WIDTH-bit words. Bits shift in at the MSB by default, which matches serial data shifted out LSB-first. Completed words are presented through a one-entry holding register with a valid/ready handshake. The block sits between a serial bit source and a parallel consumer (register file, display driver or controller) and reports words lost because the consumer was too slow.

## Interface
- WIDTH, 8: word width in bits, 2..32.
- LSB_FIRST, 1: 1 = incoming bit enters at the MSB and the word shifts right; 0 = bit enters at the LSB and the word shifts left.

- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Bit_In  in  1  serial data bit.
- Bit_Valid  in  1  Bit_In is sampled on this edge.
- Clear  in  1  synchronous abort: discards the partial word and clears Overrun.
- Data_Ready  in  1  consumer accepts Data_Out this cycle.
- Data_Out  out  WIDTH  completed word (holding register).
- Data_Valid  out  1  Data_Out holds an unconsumed word.
- Overrun  out  1  sticky flag: a completed word was dropped.
- Bit_Count  out  $clog2(WIDTH)  bits collected in the current partial word.
- Busy  out  1  partial word in progress (FSM in SHIFT).

## Operation
- Reset values: Data_Out=0, Data_Valid=0, Overrun=0, Bit_Count=0, Busy=0, internal shift register=0, FSM=IDLE.
- FSM states: IDLE (no partial word) and SHIFT (1..WIDTH-1 bits held).
  - IDLE→SHIFT on an accepted bit.
  - SHIFT→IDLE on the WIDTH-th accepted bit or on Clear.
- Accepted bit = Bit_Valid && !Clear.
  - LSB_FIRST=1: shift register ← {Bit_In, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: shift register ← {sr[WIDTH-2:0], Bit_In}.
  - Bit_Count increments; it wraps to 0 on the WIDTH-th bit.
- Word completion happens on the edge that accepts the WIDTH-th bit. The completed word is the post-shift value.
  - If holding is empty, or Data_Valid && Data_Ready this cycle: Data_Out ← word, Data_Valid=1.
  - Otherwise the word is dropped, Overrun←1, and Data_Out/Data_Valid are unchanged.
- Handshake: Data_Valid && Data_Ready consumes the word, and Data_Valid falls next cycle unless a new word completes on the same edge. Data_Out is stable while Data_Valid=1 and not consumed. Data_Ready with Data_Valid=0 has no effect.
- Clear:
  - Zeroes the shift register and Bit_Count and returns the FSM to IDLE.
  - Sets Overrun←0.
  - Leaves Data_Out/Data_Valid untouched; a handshake on the same edge still completes.
  - Clear wins over a simultaneous Bit_Valid, and that bit is dropped.
- Clear and completion never coincide, because Clear suppresses acceptance.
- Overrun is cleared only by Clear or Reset.
- Reset asserted mid-word or mid-handshake: all outputs take their reset values immediately. The partial word and any held word are lost.

## Timing
- Latency: Data_Valid rises on the same posedge that accepts the WIDTH-th bit, so it is visible the cycle after that bit is presented.
- Throughput: one bit per cycle; one word per WIDTH cycles sustained when Data_Ready is held high. No bubbles.
- Bit_Valid gaps of any length are allowed; partial state holds indefinitely.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package ser_pkg:
  - collector_state_t enum {S_IDLE, S_SHIFT}.
  - Function cnt_w(width) returning $clog2(width), reused by the transmit side.
- One sub-module, ser_shift_in: parameterised WIDTH/LSB_FIRST shift register with Shift_En and synchronous Clear and async Reset. It is the receive-side counterpart of the existing shift register.
- The top holds the FSM, the bit counter, the holding register and the handshake logic.

## Test plan
- WIDTH=8, LSB_FIRST=1, Bit_Valid=1 for 8 cycles with bits 1,0,1,0,0,1,0,1, Data_Ready=0 → Data_Valid=1 and Data_Out=0xA5 after the 8th edge; value held until Data_Ready=1, then Data_Valid=0 next cycle.
- LSB_FIRST=0, same bit sequence → Data_Out=0xA5 when bits are sent MSB-first (1,0,1,0,0,1,0,1 in the reversed sense); verify bits 1,1,0,0,0,0,0,0 → 0xC0.
- Back-to-back words 0x3C then 0xFF with Data_Ready=1 throughout → two valid words 8 cycles apart, Overrun=0, no dropped cycles.
- Data_Ready=0 while a second word (0x11) completes after 0xA5 → Data_Out stays 0xA5 and Overrun=1; then Clear → Overrun=0 and Data_Valid is still 1.
- Clear asserted together with Bit_Valid after 3 bits → Bit_Count=0 and Busy=0; next 8 bits form a clean word (0x5A) with no residue.
- Async Reset pulse between edges after 5 bits with Data_Valid=1 → all outputs 0 immediately, before the next Clk edge.
